door_sequencer: RTL and testbench
=================================

DOOR_SEQUENCER -- requirements
Module: door_sequencer

Interface
REQ-001 SHALL have parameters, one per line:
  HOLD_CYCLES, 16, clocks the door stays open with no presence before closing.
  MOTOR_TIMEOUT, 64, max clocks in OPENING or CLOSING before FAULT.
  ALARM_TRIES, 3, manual-open attempts while locked that raise alarm.
REQ-002 SHALL have ports, one per line:
  clk  in  1  single clock; all state changes on rising edge.
  reset  in  1  asynchronous, active-low reset.
  pa  in  1  person approaching.
  pp  in  1  person present in door frame.
  mo  in  1  manual open push, level.
  lk  in  1  lock request, level.
  unlk  in  1  unlock request, level.
  open_lim  in  1  both leaves at open limit.
  closed_lim  in  1  leaves at middle limit.
  open_cmd  out  1  drive motors toward open.
  close_cmd  out  1  drive motors toward middle.
  bolt  out  1  bolt engaged.
  alarm  out  1  tamper alarm, latched.
  fault  out  1  motor/sensor fault, latched.
  state  out  3  current state code.

Function
REQ-003 SHALL implement a Moore FSM: CLOSED=000, OPENING=001, OPEN_HOLD=011, CLOSING=010, LOCKED=100, FAULT=101; all outputs registered, depending only on state and latched flags.
REQ-004 SHALL drive open_cmd=1 only in OPENING and close_cmd=1 only in CLOSING; never both at once.
REQ-005 SHALL drive bolt=1 only in LOCKED and fault=1 only in FAULT.
REQ-006 CLOSED transitions, in priority order:
  lk=1 and closed_lim=1 -> LOCKED.
  pa|pp|mo -> OPENING.
  otherwise stay.
REQ-007 OPENING transitions:
  open_lim=1 -> OPEN_HOLD, loading the hold timer with HOLD_CYCLES-1.
  otherwise stay.
REQ-008 OPEN_HOLD behaviour:
  pa|pp|mo reloads the hold timer each cycle.
  otherwise the timer decrements by 1.
  timer=0 with pa=pp=mo=0 -> CLOSING.
REQ-009 CLOSING transitions, in priority order:
  pa|pp|mo -> OPENING (reversal); obstruction beats closed_lim in the same cycle.
  closed_lim=1 -> CLOSED.
REQ-010 SHALL keep a motor timer that clears on entry to OPENING or CLOSING and increments each cycle in those states; when it reaches MOTOR_TIMEOUT-1 without the target limit, next state SHALL be FAULT.
REQ-011 open_lim=1 and closed_lim=1 in the same cycle, in any state other than LOCKED, SHALL force FAULT next cycle.
REQ-012 FAULT SHALL be exited only by reset; lk, unlk, pa, pp and mo SHALL be ignored there.
REQ-013 LOCKED behaviour:
  pa and pp SHALL be ignored.
  unlk=1 -> CLOSED and clears the attempt counter.
  lk and unlk both 1 -> stay LOCKED.
REQ-014 In LOCKED, each rising edge of mo (registered 0->1) SHALL increment the attempt counter, saturating at ALARM_TRIES; reaching ALARM_TRIES SHALL set alarm=1.
REQ-015 alarm SHALL stay 1 through unlock and all states; it clears only on reset.
REQ-016 Timer widths SHALL be ceil(log2) of their parameter, minimum 1 bit; counters SHALL never wrap.

Reset
REQ-017 reset=0 SHALL asynchronously force state=CLOSED, all outputs 0, all timers, counters and the mo edge register 0.
REQ-018 Release SHALL be sampled synchronously; the first transition SHALL occur on the first rising clk edge with reset=1.
REQ-019 Reset asserted mid-OPENING or mid-CLOSING SHALL drop open_cmd and close_cmd to 0 without waiting for a clock edge.

Verification
REQ-020 pa pulse in CLOSED; open_lim set after 5 clocks -> OPENING for 5 clocks, then OPEN_HOLD for 16 clocks, then CLOSING; closed_lim -> CLOSED.
REQ-021 pp=1 in CLOSING while closed_lim=1 in the same cycle -> OPENING next cycle with open_cmd=1 and close_cmd=0.
REQ-022 lk=1 with closed_lim=1 -> LOCKED with bolt=1; 3 mo pulses -> alarm=1 after the third; unlk -> CLOSED with alarm still 1; reset -> alarm=0.
REQ-023 OPENING with open_lim held at 0 -> FAULT after 64 clocks with open_cmd=0 and fault=1; pa ignored until reset.
REQ-024 open_lim=closed_lim=1 in CLOSED -> FAULT next cycle.
REQ-025 reset=0 asserted between clock edges during CLOSING -> close_cmd=0 immediately and state=000.

Source files
------------

// File: rtl/door_sequencer.sv
// Automatic sliding door sequencer.
// Moore FSM that drives the open/close motors, the lock bolt and the
// latched tamper-alarm and fault flags. Every output is a flop that is
// cleared asynchronously by reset, so the motors stop at once when
// reset goes low.
//
// Handshake: none. All inputs are levels sampled on the rising clk edge.
// The only edge-sensitive input is mo, and only while LOCKED. It is
// compared against its own value from the previous cycle.
module door_sequencer #(
  parameter int HOLD_CYCLES   = 16,
  parameter int MOTOR_TIMEOUT = 64,
  parameter int ALARM_TRIES   = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pa,
  input  logic       pp,
  input  logic       mo,
  input  logic       lk,
  input  logic       unlk,
  input  logic       open_lim,
  input  logic       closed_lim,
  output logic       open_cmd,
  output logic       close_cmd,
  output logic       bolt,
  output logic       alarm,
  output logic       fault,
  output logic [2:0] state
);

  localparam int HW = (HOLD_CYCLES   > 1) ? $clog2(HOLD_CYCLES)   : 1;
  localparam int MW = (MOTOR_TIMEOUT > 1) ? $clog2(MOTOR_TIMEOUT) : 1;
  localparam int AW = (ALARM_TRIES   > 0) ? $clog2(ALARM_TRIES + 1) : 1;

  localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_CYCLES - 1);
  localparam logic [MW-1:0] MOT_MAX   = MW'(MOTOR_TIMEOUT - 1);
  localparam logic [AW-1:0] ATT_MAX   = AW'(ALARM_TRIES);

  typedef enum logic [2:0] {
    S_CLOSED    = 3'b000,
    S_OPENING   = 3'b001,
    S_CLOSING   = 3'b010,
    S_OPEN_HOLD = 3'b011,
    S_LOCKED    = 3'b100,
    S_FAULT     = 3'b101
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [HW-1:0]   r_hold;
  logic [HW-1:0]   w_hold_nxt;
  logic [MW-1:0]   r_motor;
  logic [MW-1:0]   w_motor_nxt;
  logic [AW-1:0]   r_att;
  logic [AW-1:0]   w_att_nxt;
  logic            r_mo_q;
  logic            r_open_cmd;
  logic            r_close_cmd;
  logic            r_bolt;
  logic            r_alarm;
  logic            r_fault;

  logic w_presence;
  logic w_both_lim;
  logic w_mo_rise;

  assign w_presence = pa | pp | mo;
  assign w_both_lim = open_lim & closed_lim;
  assign w_mo_rise  = mo & ~r_mo_q;

  // Next-state, timer and attempt-counter logic.
  always_comb begin
    w_state_nxt = r_state;
    w_hold_nxt  = r_hold;
    w_motor_nxt = r_motor;
    w_att_nxt   = r_att;
    unique case (r_state)
      S_CLOSED: begin
        if (w_both_lim)              w_state_nxt = S_FAULT;
        else if (lk && closed_lim)   w_state_nxt = S_LOCKED;
        else if (w_presence)         w_state_nxt = S_OPENING;
      end
      S_OPENING: begin
        if (w_both_lim)              w_state_nxt = S_FAULT;
        else if (open_lim) begin
          w_state_nxt = S_OPEN_HOLD;
          w_hold_nxt  = HOLD_LOAD;
        end
        else if (r_motor == MOT_MAX) w_state_nxt = S_FAULT;
      end
      S_OPEN_HOLD: begin
        if (w_both_lim)              w_state_nxt = S_FAULT;
        else if (w_presence)         w_hold_nxt  = HOLD_LOAD;
        else if (r_hold == '0)       w_state_nxt = S_CLOSING;
        else                         w_hold_nxt  = r_hold - 1'b1;
      end
      S_CLOSING: begin
        // An obstruction always reverses, even if the leaves just met.
        if (w_both_lim)              w_state_nxt = S_FAULT;
        else if (w_presence)         w_state_nxt = S_OPENING;
        else if (closed_lim)         w_state_nxt = S_CLOSED;
        else if (r_motor == MOT_MAX) w_state_nxt = S_FAULT;
      end
      S_LOCKED: begin
        if (unlk && !lk) begin
          w_state_nxt = S_CLOSED;
          w_att_nxt   = '0;
        end
        else if (w_mo_rise && (r_att != ATT_MAX)) begin
          w_att_nxt = r_att + 1'b1;
        end
      end
      S_FAULT: begin
        w_state_nxt = S_FAULT;
      end
      default: w_state_nxt = S_FAULT;
    endcase

    // The motor timer restarts on every entry into a motion state,
    // including a reversal, and saturates rather than wrapping.
    if (w_state_nxt != r_state)
      w_motor_nxt = '0;
    else if ((r_state == S_OPENING || r_state == S_CLOSING) && (r_motor != MOT_MAX))
      w_motor_nxt = r_motor + 1'b1;
  end

  // State, timers, mo history and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_CLOSED;
      r_hold      <= '0;
      r_motor     <= '0;
      r_att       <= '0;
      r_mo_q      <= 1'b0;
      r_open_cmd  <= 1'b0;
      r_close_cmd <= 1'b0;
      r_bolt      <= 1'b0;
      r_alarm     <= 1'b0;
      r_fault     <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_hold      <= w_hold_nxt;
      r_motor     <= w_motor_nxt;
      r_att       <= w_att_nxt;
      r_mo_q      <= mo;
      r_open_cmd  <= (w_state_nxt == S_OPENING);
      r_close_cmd <= (w_state_nxt == S_CLOSING);
      r_bolt      <= (w_state_nxt == S_LOCKED);
      r_fault     <= (w_state_nxt == S_FAULT);
      r_alarm     <= r_alarm | (w_att_nxt == ATT_MAX);
    end
  end

  assign open_cmd  = r_open_cmd;
  assign close_cmd = r_close_cmd;
  assign bolt      = r_bolt;
  assign alarm     = r_alarm;
  assign fault     = r_fault;
  assign state     = r_state;

endmodule

// File: tb/tb_door_sequencer.sv
// Testbench for door_sequencer: directed scenarios followed by randomized
// traffic that is checked against a behavioural door model.
module tb_door_sequencer;

  localparam int HOLD = 16;
  localparam int MTO  = 64;
  localparam int TRY  = 3;

  localparam int C_CLOSED = 0, C_OPENING = 1, C_CLOSING = 2,
                 C_HOLD = 3, C_LOCKED = 4, C_FAULT = 5;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic pa = 1'b0, pp = 1'b0, mo = 1'b0, lk = 1'b0, unlk = 1'b0;
  logic open_lim = 1'b0, closed_lim = 1'b0;
  logic open_cmd, close_cmd, bolt, alarm, fault;
  logic [2:0] state;

  int n_tests = 0;
  int n_fail  = 0;

  // Behavioural model of the door.
  int m_state, m_hold_left, m_motion_cycles, m_tries, m_alarm, m_mo_prev;

  door_sequencer #(.HOLD_CYCLES(HOLD), .MOTOR_TIMEOUT(MTO), .ALARM_TRIES(TRY)) dut (
    .clk(clk), .reset(reset), .pa(pa), .pp(pp), .mo(mo), .lk(lk), .unlk(unlk),
    .open_lim(open_lim), .closed_lim(closed_lim), .open_cmd(open_cmd),
    .close_cmd(close_cmd), .bolt(bolt), .alarm(alarm), .fault(fault), .state(state)
  );

  // Clock generation.
  always #5 clk = ~clk;

  task automatic model_reset();
    m_state = C_CLOSED; m_hold_left = 0; m_motion_cycles = 0;
    m_tries = 0; m_alarm = 0; m_mo_prev = 0;
  endtask

  // One clock of the door model, applied to the inputs present at the edge.
  task automatic model_step();
    int  nxt;
    bit  someone;
    bit  both;
    someone = pa || pp || mo;
    both    = open_lim && closed_lim;
    nxt = m_state;
    if (m_state == C_LOCKED) begin
      if (unlk && !lk) begin
        nxt = C_CLOSED;
        m_tries = 0;
      end else if (mo && !m_mo_prev && m_tries < TRY) begin
        m_tries++;
      end
    end else if (m_state == C_FAULT) begin
      nxt = C_FAULT;
    end else if (both) begin
      nxt = C_FAULT;
    end else if (m_state == C_CLOSED) begin
      if (lk && closed_lim) nxt = C_LOCKED;
      else if (someone)     nxt = C_OPENING;
    end else if (m_state == C_OPENING) begin
      if (open_lim) begin
        nxt = C_HOLD;
        m_hold_left = HOLD - 1;
      end else if (m_motion_cycles == MTO - 1) nxt = C_FAULT;
      else m_motion_cycles++;
    end else if (m_state == C_HOLD) begin
      if (someone)                nm_reload();
      else if (m_hold_left == 0)  nxt = C_CLOSING;
      else                        m_hold_left--;
    end else if (m_state == C_CLOSING) begin
      if (someone)         nxt = C_OPENING;
      else if (closed_lim) nxt = C_CLOSED;
      else if (m_motion_cycles == MTO - 1) nxt = C_FAULT;
      else m_motion_cycles++;
    end
    if (nxt != m_state) m_motion_cycles = 0;
    if (m_tries == TRY) m_alarm = 1;
    m_mo_prev = mo;
    m_state = nxt;
  endtask

  task automatic nm_reload();
    m_hold_left = HOLD - 1;
  endtask

  // Advance one clock; outputs are stable 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic clear_inputs();
    pa = 0; pp = 0; mo = 0; lk = 0; unlk = 0; open_lim = 0; closed_lim = 0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    clear_inputs();
    reset = 0;
    model_reset();
    #2;
    reset = 1;
    tick();
  endtask

  // Walk the door from CLOSED to the first CLOSING cycle.
  task automatic goto_closing();
    int n;
    pa = 1; tick(); pa = 0;
    open_lim = 1; tick();
    n = 0;
    while (state != 3'(C_CLOSING) && n < 40) begin tick(); n++; end
    open_lim = 0;
  endtask

  task automatic test_reset();
    clear_inputs();
    reset = 0;
    model_reset();
    #3;
    n_tests++;
    if ({state, open_cmd, close_cmd, bolt, alarm, fault} !== 8'b0) begin
      n_fail++;
      $display("FAIL reset_values: got state=%b o=%b c=%b b=%b a=%b f=%b, want all 0",
               state, open_cmd, close_cmd, bolt, alarm, fault);
    end
    // Hold pa through release: the first edge with reset high must open.
    pa = 1;
    @(negedge clk);
    reset = 1;
    tick();
    pa = 0;
    n_tests++;
    if (state !== 3'b001 || open_cmd !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_release_first_edge: got state=%b open_cmd=%b, want 001/1", state, open_cmd);
    end
  endtask

  task automatic test_open_cycle();
    int n;
    bit bad;
    apply_reset();
    pa = 1; tick(); pa = 0;
    bad = 0;
    for (int i = 1; i <= 5; i++) begin
      if (state !== 3'b001 || open_cmd !== 1'b1 || close_cmd !== 1'b0) bad = 1;
      if (i == 5) open_lim = 1;
      tick();
    end
    n_tests++;
    if (bad) begin
      n_fail++;
      $display("FAIL opening_5_cycles: state=%b open_cmd=%b left OPENING early, want 001/1 for 5 clocks", state, open_cmd);
    end
    n = 0;
    while (state === 3'b011 && n < 40) begin tick(); n++; end
    open_lim = 0;
    n_tests++;
    if (n != 16 || state !== 3'b010 || close_cmd !== 1'b1) begin
      n_fail++;
      $display("FAIL hold_16_then_closing: hold=%0d state=%b close_cmd=%b, want 16/010/1", n, state, close_cmd);
    end
    tick(); tick();
    closed_lim = 1; tick(); closed_lim = 0;
    n_tests++;
    if (state !== 3'b000 || close_cmd !== 1'b0 || open_cmd !== 1'b0) begin
      n_fail++;
      $display("FAIL closing_to_closed: state=%b close_cmd=%b, want 000/0", state, close_cmd);
    end
  endtask

  task automatic test_reversal();
    apply_reset();
    goto_closing();
    pp = 1; closed_lim = 1; tick(); pp = 0; closed_lim = 0;
    n_tests++;
    if (state !== 3'b001 || open_cmd !== 1'b1 || close_cmd !== 1'b0) begin
      n_fail++;
      $display("FAIL reversal_beats_closed_lim: state=%b o=%b c=%b, want 001/1/0", state, open_cmd, close_cmd);
    end
  endtask

  task automatic test_lock_alarm();
    apply_reset();
    lk = 1; closed_lim = 1; tick(); lk = 0;
    n_tests++;
    if (state !== 3'b100 || bolt !== 1'b1) begin
      n_fail++;
      $display("FAIL lock_entry: state=%b bolt=%b, want 100/1", state, bolt);
    end
    pa = 1; pp = 1; tick(); pa = 0; pp = 0;
    n_tests++;
    if (state !== 3'b100) begin
      n_fail++;
      $display("FAIL locked_ignores_presence: state=%b, want 100", state);
    end
    for (int i = 1; i <= 3; i++) begin
      mo = 1; tick(); mo = 0; tick();
      if (i == 2) begin
        n_tests++;
        if (alarm !== 1'b0) begin
          n_fail++;
          $display("FAIL alarm_after_two: alarm=%b, want 0", alarm);
        end
      end
    end
    n_tests++;
    if (alarm !== 1'b1 || state !== 3'b100) begin
      n_fail++;
      $display("FAIL alarm_after_three: alarm=%b state=%b, want 1/100", alarm, state);
    end
    lk = 1; unlk = 1; tick(); lk = 0;
    n_tests++;
    if (state !== 3'b100) begin
      n_fail++;
      $display("FAIL lk_unlk_stays_locked: state=%b, want 100", state);
    end
    tick(); unlk = 0; closed_lim = 0;
    n_tests++;
    if (state !== 3'b000 || alarm !== 1'b1 || bolt !== 1'b0) begin
      n_fail++;
      $display("FAIL unlock_keeps_alarm: state=%b alarm=%b bolt=%b, want 000/1/0", state, alarm, bolt);
    end
    apply_reset();
    n_tests++;
    if (alarm !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_clears_alarm: alarm=%b, want 0", alarm);
    end
  endtask

  task automatic test_motor_timeout();
    int n;
    apply_reset();
    pa = 1; tick(); pa = 0;
    n = 0;
    while (state === 3'b001 && n < 200) begin tick(); n++; end
    n_tests++;
    if (n != 64 || state !== 3'b101 || open_cmd !== 1'b0 || fault !== 1'b1) begin
      n_fail++;
      $display("FAIL open_timeout: cycles=%0d state=%b o=%b f=%b, want 64/101/0/1", n, state, open_cmd, fault);
    end
    pa = 1; unlk = 1; mo = 1; lk = 1;
    repeat (5) tick();
    clear_inputs();
    n_tests++;
    if (state !== 3'b101 || fault !== 1'b1) begin
      n_fail++;
      $display("FAIL fault_sticky: state=%b fault=%b, want 101/1", state, fault);
    end
  endtask

  task automatic test_both_limits();
    apply_reset();
    open_lim = 1; closed_lim = 1; tick(); open_lim = 0; closed_lim = 0;
    n_tests++;
    if (state !== 3'b101 || fault !== 1'b1) begin
      n_fail++;
      $display("FAIL both_limits_fault: state=%b fault=%b, want 101/1", state, fault);
    end
  endtask

  task automatic test_async_reset();
    apply_reset();
    goto_closing();
    n_tests++;
    if (state !== 3'b010 || close_cmd !== 1'b1) begin
      n_fail++;
      $display("FAIL reach_closing: state=%b close_cmd=%b, want 010/1", state, close_cmd);
    end
    #2;
    reset = 0;
    model_reset();
    #1;
    n_tests++;
    if (close_cmd !== 1'b0 || state !== 3'b000) begin
      n_fail++;
      $display("FAIL async_reset_closing: close_cmd=%b state=%b, want 0/000", close_cmd, state);
    end
    @(negedge clk);
    reset = 1;
  endtask

  task automatic test_random();
    int r;
    logic [7:0] exp_v;
    apply_reset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (cyc % 150 == 149) begin
        apply_reset();
      end else begin
        pa   = ($urandom_range(0, 9) == 0);
        pp   = ($urandom_range(0, 11) == 0);
        mo   = ($urandom_range(0, 5) == 0);
        lk   = ($urandom_range(0, 4) == 0);
        unlk = ($urandom_range(0, 6) == 0);
        r = $urandom_range(0, 99);
        open_lim   = (r < 20) || (r == 40);
        closed_lim = (r >= 20 && r <= 40);
        tick();
      end
      exp_v = {3'(m_state), m_state == C_OPENING, m_state == C_CLOSING,
               m_state == C_LOCKED, m_alarm != 0, m_state == C_FAULT};
      n_tests++;
      if ({state, open_cmd, close_cmd, bolt, alarm, fault} !== exp_v) begin
        n_fail++;
        $display("FAIL random_cycle_%0d: got {state,o,c,b,a,f}=%b, want %b", cyc,
                 {state, open_cmd, close_cmd, bolt, alarm, fault}, exp_v);
      end
    end
    clear_inputs();
  endtask

  initial begin
    test_reset();
    test_open_cycle();
    test_reversal();
    test_lock_alarm();
    test_motor_timeout();
    test_both_limits();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
